// File: rtl/triangle_sequencer.sv
// Drives a triangle generator's ena/rst for a set number of periods with a programmable step interval.
// Start sampled at edge t -> ARM in cycle t+1 -> RUN from t+2; no backpressure, start ignored while busy.
module triangle_sequencer #(
   parameter int N     = 8,
   parameter int DIV_W = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [DIV_W-1:0] divisor,
   input  logic [CNT_W-1:0] periods,
   output logic             tri_ena,
   output logic             tri_rst,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] period_count
);

   typedef enum logic [1:0] {IDLE, ARM, RUN, FINISH} state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] presc;
   logic [N:0]       step;
   logic             stop_pend;
   logic [DIV_W-1:0] div_q;
   logic [CNT_W-1:0] per_q;
   logic             boundary;
   logic             last_period;
   logic [CNT_W:0]   count_inc;

   assign tri_ena  = (state == RUN) && (presc == div_q);
   assign tri_rst  = ~rst | (state == ARM);
   assign busy     = (state != IDLE);
   assign done     = (state == FINISH);
   assign boundary = tri_ena && (step == '1);

   // Widened by one bit so the compare is exact even when period_count is saturated.
   assign count_inc   = {1'b0, period_count} + {{CNT_W{1'b0}}, 1'b1};
   assign last_period = (per_q != '0) && (count_inc >= {1'b0, per_q});

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ARM;
         ARM:     state_nxt = RUN;
         RUN:     if (boundary && (last_period || stop_pend || stop)) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         presc        <= '0;
         step         <= '0;
         stop_pend    <= 1'b0;
         div_q        <= '0;
         per_q        <= '0;
         period_count <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               stop_pend <= 1'b0;
               if (start) begin
                  div_q <= divisor;
                  per_q <= periods;
               end
            end
            ARM: begin
               presc        <= '0;
               step         <= '0;
               period_count <= '0;
               stop_pend    <= stop;
            end
            RUN: begin
               stop_pend <= stop_pend | stop;
               if (tri_ena) begin
                  presc <= '0;
                  step  <= step + {{N{1'b0}}, 1'b1};
                  if (boundary && (period_count != '1))
                     period_count <= count_inc[CNT_W-1:0];
               end else begin
                  presc <= presc + {{(DIV_W-1){1'b0}}, 1'b1};
               end
            end
            FINISH:  stop_pend <= 1'b0;
            default: stop_pend <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_triangle_sequencer.sv
// Randomized and directed check of triangle_sequencer (N=2) against a closed-form per-cycle schedule model.
module tb_triangle_sequencer;

   localparam int N     = 2;
   localparam int DIV_W = 16;
   localparam int CNT_W = 8;
   localparam int STEPS = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [DIV_W-1:0] divisor = '0;
   logic [CNT_W-1:0] periods = '0;
   logic             tri_ena, tri_rst, busy, done;
   logic [CNT_W-1:0] period_count;

   triangle_sequencer #(.N(N), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .divisor(divisor), .periods(periods),
      .tri_ena(tri_ena), .tri_rst(tri_rst), .busy(busy), .done(done),
      .period_count(period_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model of the current run: start edge, latched divisor, run length in RUN cycles, final period count.
   bit run_active = 0;
   int t_start, d_m, len_m, pend_m, prev_pc, idle_pc = 0;
   int ena_cnt, done_cnt, gen;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Generator stand-in: step count modulo one period.
   always @(posedge clk)
      if (tri_rst) gen <= 0;
      else if (tri_ena) gen <= (gen + 1) % STEPS;

   always @(negedge clk) begin
      if (tri_ena) ena_cnt++;
      if (done) done_cnt++;
   end

   always @(negedge clk) begin
      int k, i, e_ena, e_trst, e_busy, e_done, e_pc;
      k = cyc - t_start;
      e_ena = 0; e_trst = 0; e_busy = 0; e_done = 0; e_pc = idle_pc;
      if (!rst) begin
         e_trst = 1; e_pc = 0;
      end else if (run_active && k >= 0 && k <= len_m + 1) begin
         e_busy = 1;
         if (k == 0) begin
            e_trst = 1; e_pc = prev_pc;
         end else if (k <= len_m) begin
            i = k - 1;
            e_ena = ((i + 1) % (d_m + 1) == 0);
            e_pc  = (i / (d_m + 1)) / STEPS;
         end else begin
            e_done = 1; e_pc = pend_m;
            check("gen_zero_at_done", gen, 0);
         end
      end
      check("tri_ena", tri_ena, e_ena);
      check("tri_rst", tri_rst, e_trst);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("period_count", period_count, e_pc);
   end

   // stop_r: RUN index whose closing edge samples stop (-1 = during ARM, -2 = none).
   task automatic run(input int d, input int p, input int stop_r, input bit noise, input int abort_k);
      int s, pstop, pend;
      @(negedge clk);
      divisor = DIV_W'(d);
      periods = CNT_W'(p);
      start = 1'b1;
      s = STEPS * (d + 1);
      pstop = (stop_r + 1 + s - 1) / s;
      if (pstop < 1) pstop = 1;
      if (stop_r < -1) pend = p;
      else if (p == 0 || pstop < p) pend = pstop;
      else pend = p;
      @(posedge clk); #1;
      t_start = cyc; d_m = d; pend_m = pend; len_m = pend * s;
      prev_pc = idle_pc; run_active = 1; ena_cnt = 0; done_cnt = 0;
      for (int k = 0; k <= len_m + 1; k++) begin
         @(negedge clk);
         start = 1'b0;
         stop  = (k == stop_r + 1) && (stop_r >= -1);
         if (noise && k == len_m / 2) begin
            start   = 1'b1;
            divisor = DIV_W'($urandom_range(0, 7));
            periods = CNT_W'($urandom_range(0, 7));
         end
         if (k == abort_k) begin
            stop = 1'b0;
            @(posedge clk); #2;
            rst = 1'b0;
            run_active = 0; idle_pc = 0;
            #1;
            check("abort_busy", busy, 0);
            check("abort_tri_ena", tri_ena, 0);
            check("abort_tri_rst", tri_rst, 1);
            check("abort_done", done, 0);
            repeat (2) @(negedge clk);
            #2 rst = 1'b1;
            repeat (2) @(negedge clk);
            check("abort_no_done", done_cnt, 0);
            return;
         end
      end
      stop = 1'b0;
      @(posedge clk); #1;
      run_active = 0; idle_pc = pend;
   endtask

   initial begin
      #1;
      check("rst_tri_ena", tri_ena, 0);
      check("rst_tri_rst", tri_rst, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_period_count", period_count, 0);
      #21 rst = 1'b1;

      // stop in IDLE must be ignored
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      check("idle_stop_busy", busy, 0);

      run(0, 1, -2, 0, -1);
      check("basic_len", len_m, 8);
      check("basic_pulses", ena_cnt, 8);
      check("basic_done", done_cnt, 1);
      check("basic_pc", period_count, 1);

      run(2, 2, -2, 0, -1);
      check("div2_pulses", ena_cnt, 16);
      check("div2_done", done_cnt, 1);
      check("div2_pc", period_count, 2);

      run(0, 0, 3, 0, -1);
      check("stop_pulses", ena_cnt, 8);
      check("stop_pc", period_count, 1);

      run(1, 1, -2, 1, -1);
      check("noise_pulses", ena_cnt, 8);
      check("noise_done", done_cnt, 1);

      run(1, 2, -2, 0, 5);
      run(0, 1, -2, 0, -1);
      check("post_abort_pulses", ena_cnt, 8);
      check("post_abort_pc", period_count, 1);

      run(0, 1, 7, 0, -1);
      check("stop_at_end_pulses", ena_cnt, 8);
      check("stop_at_end_done", done_cnt, 1);
      check("stop_at_end_pc", period_count, 1);

      run(3, 1, -1, 0, -1);
      check("arm_stop_pulses", ena_cnt, 8);

      for (int n = 0; n < 12; n++) begin
         int d, p, r, lim;
         d = $urandom_range(0, 3);
         p = $urandom_range(0, 3);
         lim = ((p == 0) ? 3 : p) * STEPS * (d + 1) - 1;
         r = -2;
         if (p == 0 || $urandom_range(0, 1) == 1) r = $urandom_range(0, lim + 1) - 1;
         run(d, p, r, $urandom_range(0, 1) == 1, -1);
         check("rand_pulses", ena_cnt, pend_m * STEPS);
         check("rand_done", done_cnt, 1);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/triangle_sequencer.md
TRIANGLE_SEQUENCER -- requirements
Module: triangle_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, giving the data width of the driven triangle generator (period = 2^(N+1) enable steps).
REQ-002 SHALL have parameter DIV_W, default 16, giving the prescaler divisor width.
REQ-003 SHALL have parameter CNT_W, default 8, giving the period-count width.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assertion, active-low.
REQ-006 SHALL have port start  input  1  run request, sampled on the rising edge of clk.
REQ-007 SHALL have port stop  input  1  graceful-stop request, sampled on the rising edge of clk.
REQ-008 SHALL have port divisor  input  DIV_W  step interval minus one, latched at start.
REQ-009 SHALL have port periods  input  CNT_W  number of full periods to run, latched at start; 0 = continuous.
REQ-010 SHALL have port tri_ena  output  1  step strobe to the generator's ena input.
REQ-011 SHALL have port tri_rst  output  1  active-high synchronous clear to the generator's rst input.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port period_count  output  CNT_W  periods completed in the current or last run.

Function
REQ-015 SHALL implement states IDLE, ARM, RUN, FINISH; tri_rst = 1 in ARM, busy = 1 in ARM/RUN/FINISH, done = 1 only in FINISH.
REQ-016 IDLE: on start = 1 SHALL latch divisor and periods into div_q/per_q and go to ARM; stop ignored in IDLE.
REQ-017 ARM (exactly one cycle): SHALL clear prescaler, step counter (N+1 bits) and period_count, then go to RUN.
REQ-018 RUN: prescaler SHALL count 0..div_q; tri_ena = 1 (combinational from state and prescaler) in each cycle where prescaler == div_q, and the prescaler then returns to 0; otherwise it increments.
REQ-019 divisor = 0 SHALL give tri_ena = 1 on every RUN cycle; tri_ena SHALL be 0 outside RUN.
REQ-020 Step counter SHALL increment modulo 2^(N+1) on every tri_ena cycle, mirroring the generator's internal count.
REQ-021 A tri_ena cycle with step counter all-ones SHALL be a period boundary: period_count increments (saturating at 2^CNT_W-1).
REQ-022 At a period boundary, if (per_q != 0 and period_count+1 >= per_q) or stop is pending, next state SHALL be FINISH; otherwise stay in RUN.
REQ-023 stop = 1 in ARM or RUN SHALL set a stop-pending flag, cleared in ARM and IDLE; a stop and a boundary in the same cycle SHALL end the run at that boundary.
REQ-024 FINISH (exactly one cycle) SHALL go to IDLE; period_count SHALL hold until the next ARM.
REQ-025 start while busy SHALL be ignored; divisor/periods changes while busy SHALL have no effect.
REQ-026 Run latency: start sampled at edge t -> ARM during cycle t+1 -> RUN from t+2; first tri_ena in RUN cycle div_q+1.

Reset
REQ-027 rst = 0 SHALL asynchronously force state IDLE and prescaler, step counter, stop flag, div_q, per_q, period_count to 0.
REQ-028 During reset: tri_ena = 0, busy = 0, done = 0, period_count = 0, and tri_rst = 1 (tri_rst = ~rst | ARM), so the generator is cleared.
REQ-029 Reset asserted mid-run SHALL abort without a done pulse; after release the block waits in IDLE for start.

Verification (N = 2, period = 8 steps)
REQ-030 divisor=0, periods=1, start pulse at edge t -> tri_rst=1 cycle t+1; tri_ena=1 cycles t+2..t+9; done=1 cycle t+10 only; period_count=1; busy low from t+11.
REQ-031 divisor=2, periods=2 -> tri_ena every 3rd RUN cycle, 16 pulses total, done once, period_count=2; a generator model returns to 0 at done.
REQ-032 periods=0, stop pulsed after 3 tri_ena pulses -> run continues to 8th pulse, then FINISH; period_count=1.
REQ-033 start re-pulsed and divisor changed mid-run -> ignored; pulse spacing and total unchanged.
REQ-034 rst driven low mid-RUN between clock edges -> busy/tri_ena drop immediately, tri_rst=1, no done; a fresh start after release behaves as in REQ-030.
REQ-035 stop and final boundary in the same cycle, periods=1 -> single done, period_count=1, no extra period.
